// File: rtl/tdma_send_sched.sv
// TDMA transmit scheduler: queues Nios send requests in a small FIFO and
// emits at most one queued {addr, payload} word per frame in this node's slot.
module tdma_send_sched #(
  parameter int NODE_ID    = 0,
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_LEN   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  send_addr,
  input  logic [23:0] send_data,
  input  logic        send_req,
  output logic [31:0] tdm_out,
  output logic        tdm_valid,
  output logic [7:0]  slot_num,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [7:0]  drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0]       CYC_LAST  = 8'(SLOT_LEN - 1);
  localparam logic [7:0]       SLOT_LAST = 8'(NUM_SLOTS - 1);
  localparam logic [7:0]       OWN_SLOT  = 8'(NODE_ID);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  logic [7:0]       cyc_q, cyc_d;
  logic [7:0]       slot_q, slot_d;
  logic             req_q, req_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      out_q, out_d;
  logic             valid_q, valid_d;
  logic [7:0]       drop_q, drop_d;
  logic [31:0]      mem_q [FIFO_DEPTH];

  logic rise, pop, push, drop;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cyc_d    = cyc_q + 8'd1;
    slot_d   = slot_q;
    req_d    = send_req;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = '0;
    valid_d  = 1'b0;
    drop_d   = drop_q;

    if (cyc_q == CYC_LAST) begin
      cyc_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 8'd1;
    end

    rise = send_req & ~req_q;
    pop  = (slot_q == OWN_SLOT) && (cyc_q == '0) && (count_q != '0);
    // A pop in the same cycle frees the slot a full queue would otherwise refuse.
    push = rise & ((count_q != DEPTH_C) | pop);
    drop = rise & ~push;

    if (pop) begin
      out_d    = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q    <= '0;
      slot_q   <= '0;
      req_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      cyc_q    <= cyc_d;
      slot_q   <= slot_d;
      req_q    <= req_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q guards every read, so
  // stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {send_addr, send_data};
    end
  end

  assign tdm_out    = out_q;
  assign tdm_valid  = valid_q;
  assign slot_num   = slot_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_tdma_send_sched.sv
// Self-checking bench for tdma_send_sched: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based frame model.
module tb_tdma_send_sched;

  localparam int NODE_ID   = 2;
  localparam int NUM_SLOTS = 8;
  localparam int SLOT_LEN  = 4;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  send_addr = '0;
  logic [23:0] send_data = '0;
  logic        send_req = 1'b0;
  logic [31:0] tdm_out;
  logic        tdm_valid;
  logic [7:0]  slot_num;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  drop_cnt;

  tdma_send_sched #(
    .NODE_ID   (NODE_ID),
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_LEN  (SLOT_LEN),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .send_addr (send_addr),
    .send_data (send_data),
    .send_req  (send_req),
    .tdm_out   (tdm_out),
    .tdm_valid (tdm_valid),
    .slot_num  (slot_num),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: t counts clock edges since reset release.
  int          t;
  logic [31:0] q[$];
  bit          req_prev;
  int          drop;
  bit          exp_valid;
  logic [31:0] exp_out;
  int          pulses;
  logic [31:0] sent[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    q.delete();
    req_prev  = 1'b0;
    drop      = 0;
    exp_valid = 1'b0;
    exp_out   = '0;
  endtask

  task automatic check_outputs();
    check("tdm_valid", 32'(tdm_valid), 32'(exp_valid));
    check("tdm_out", tdm_out, exp_out);
    check("slot_num", 32'(slot_num), 32'((t / SLOT_LEN) % NUM_SLOTS));
    check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    check("drop_cnt", 32'(drop_cnt), 32'(drop));
  endtask

  // Check the current cycle, apply inputs, advance the model across one edge.
  task automatic cycle(input bit req, input logic [7:0] a, input logic [23:0] d);
    int slot_m;
    int cyc_m;
    bit pop_m;
    bit rise_m;
    check_outputs();
    if (tdm_valid) begin
      pulses++;
      sent.push_back(tdm_out);
    end
    send_req  = req;
    send_addr = a;
    send_data = d;
    slot_m = (t / SLOT_LEN) % NUM_SLOTS;
    cyc_m  = t % SLOT_LEN;
    pop_m  = (slot_m == NODE_ID) && (cyc_m == 0) && (q.size() > 0);
    rise_m = req && !req_prev;
    exp_valid = pop_m;
    exp_out   = '0;
    if (pop_m) begin
      exp_out = q[0];
      void'(q.pop_front());
    end
    if (rise_m) begin
      if (q.size() < DEPTH) q.push_back({a, d});
      else if (drop < 255) drop++;
    end
    req_prev = req;
    t++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases on a negedge.
  task automatic do_reset(input bit req_during);
    #2;
    reset_n  = 1'b0;
    send_req = req_during;
    #1;
    check("rst_tdm_valid", 32'(tdm_valid), 32'd0);
    check("rst_tdm_out", tdm_out, 32'd0);
    check("rst_slot_num", 32'(slot_num), 32'd0);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    send_req = 1'b0;
    reset_n  = 1'b1;
    model_reset();
    pulses = 0;
    sent.delete();
  endtask

  initial begin
    model_reset();
    pulses = 0;

    // Reset with request held high, then idle slot stepping.
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 24'h0);

    // Single send.
    do_reset(1'b0);
    for (int i = 0; i < 48; i++) begin
      if (t == 3) check("single_empty", 32'(fifo_empty), 32'd0);
      if (t == 9) begin
        check("single_valid", 32'(tdm_valid), 32'd1);
        check("single_word", tdm_out, 32'h05ABCDEF);
      end
      if (t == 41) check("single_no_repeat", 32'(tdm_valid), 32'd0);
      cycle(i >= 2 && i < 6, 8'h05, 24'hABCDEF);
    end
    check("single_pulses", pulses, 1);

    // Held level: one enqueue only.
    do_reset(1'b0);
    for (int i = 0; i < 128; i++) cycle(i < 100, 8'h11, 24'(i));
    check("held_pulses", pulses, 1);
    check("held_drop", 32'(drop_cnt), 32'd0);

    // Overflow and full-plus-pop: rises at 0,2,4,6 fill, 8 coincides with pop, 10 drops.
    do_reset(1'b0);
    for (int i = 0; i < 172; i++) begin
      if (t == 7) check("ovf_full", 32'(fifo_full), 32'd1);
      if (t == 9) begin
        check("fullpop_full", 32'(fifo_full), 32'd1);
        check("fullpop_drop", 32'(drop_cnt), 32'd0);
      end
      if (t == 11) check("ovf_drop", 32'(drop_cnt), 32'd1);
      cycle(i inside {0, 2, 4, 6, 8, 10}, 8'hA0, 24'(i / 2 + 1));
    end
    check("ovf_count", sent.size(), 5);
    for (int k = 0; k < 5 && k < sent.size(); k++)
      check("ovf_order", sent[k], {8'hA0, 24'(k + 1)});
    check("ovf_empty_end", 32'(fifo_empty), 32'd1);

    // Async reset mid-run with two queued entries.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) cycle(i == 10 || i == 12, 8'h33, 24'(i));
    check("mid_pending", 32'(fifo_empty), 32'd0);
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 24'h0);
    check("mid_no_stale", pulses, 0);

    // Random traffic with occasional resets.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1499) == 0) do_reset(1'b0);
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 24'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdma_send_sched.md
# tdma_send_sched

Transmit scheduler between the Nios send-side PIOs (8-bit destination address, 24-bit payload, request bit) and the TDMA network link. Each request edge queues one {address, payload} word in a small FIFO. The block keeps a free-running TDMA slot counter and emits at most one queued word per frame, in this node's own slot. Status outputs feed back to Nios PIO inputs for software flow control.

## Interface
- NODE_ID, 0: slot index owned by this node; 0..NUM_SLOTS-1.
- NUM_SLOTS, 8: slots per TDMA frame; 2..256.
- SLOT_LEN, 4: clock cycles per slot; 2..256.
- FIFO_DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- send_addr  in  8  destination address from the Nios address PIO.
- send_data  in  24  payload from the Nios data PIO.
- send_req  in  1  request bit from Nios; a 0→1 transition enqueues one word.
- tdm_out  out  32  link word {addr[31:24], payload[23:0]}; 0 when tdm_valid is low.
- tdm_valid  out  1  one-cycle strobe qualifying tdm_out.
- slot_num  out  8  current slot index, zero-extended.
- fifo_empty  out  1  queue holds no entries.
- fifo_full  out  1  queue holds FIFO_DEPTH entries.
- drop_cnt  out  8  count of requests lost to a full queue; saturates at 255.

## Operation
- Reset, asynchronous: cyc=0, slot=0, FIFO pointers and count=0, req_d=0, tdm_out=0, tdm_valid=0, drop_cnt=0. Resulting outputs: fifo_empty=1, fifo_full=0, slot_num=0.
- Slot counter: cyc increments every cycle. At cyc==SLOT_LEN-1, cyc wraps to 0 and slot increments. At slot==NUM_SLOTS-1, slot wraps to 0. The counter never stalls.
- Edge detect: req_d <= send_req; rise = send_req & ~req_d. A level held high produces exactly one enqueue. A high level at reset release counts as a rise.
- Push: on rise, {send_addr, send_data} as sampled that cycle is written at the write pointer if (count<FIFO_DEPTH) or a pop happens in the same cycle. Otherwise the word is discarded and drop_cnt increments, saturating.
- Pop: when slot==NODE_ID, cyc==0 and count>0, the head entry is registered into tdm_out, tdm_valid<=1, and the read pointer advances. In every other cycle, tdm_valid<=0 and tdm_out<=0.
- Simultaneous push and pop: both take effect and count is unchanged. When the queue is empty, push and pop cannot coincide because pop requires count>0.
- Order is strict FIFO. Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.
- Reset mid-operation discards all queued entries and restarts the frame at slot 0.

## Timing
- send_req rise sampled at edge t: the entry is visible at t+1 (fifo_empty falls at t+1).
- Pop decision at the edge where slot==NODE_ID and cyc==0. tdm_valid/tdm_out are high for the following cycle only.
- Throughput is at most one word per NUM_SLOTS*SLOT_LEN cycles.
- All outputs are registered. slot_num, fifo_empty and fifo_full are derived from registers with no combinational path from inputs.
- Latency from push to transmit is 1..NUM_SLOTS*SLOT_LEN+1 cycles for the head entry.

## Test plan
Defaults with NODE_ID=2: frame = 32 cycles; own-slot cyc 0 falls at cycle 8 after reset release.
- Reset: hold reset_n low, drive send_req=1 → all outputs 0 except fifo_empty=1. Release with send_req=0 → slot_num steps 0,1,2 every 4 cycles.
- Single send: addr=0x05, data=0xABCDEF, send_req 0→1 at cycle 2 → fifo_empty=0 at cycle 3. tdm_out=0x05ABCDEF with tdm_valid=1 at cycle 9 only. tdm_valid stays 0 at cycle 41.
- Held level: send_req high for 100 cycles → exactly one tdm_valid pulse across 4 frames. drop_cnt=0.
- Overflow: 5 request edges with data 1..5 before cycle 8 → fifo_full=1 and drop_cnt=1. Words 1,2,3,4 appear at cycles 9,41,73,105. fifo_empty=1 after cycle 104.
- Full plus pop: queue full, rise on the same edge as pop at cycle 40 → push accepted, fifo_full stays 1, drop_cnt unchanged. Later pops are in order with the new word last.
- Async reset mid-run: 2 entries queued, reset_n low at cycle 20 between edges → tdm_valid=0 and fifo_empty=1 immediately. After release, slot_num restarts at 0 and no stale word is transmitted.
